// File: rtl/mips_isa_pkg.sv
// Shared mini-MIPS ISA definitions: opcode values, instruction type codes and
// the loader state encoding. Both the decode stage and the encode loader import
// this package so the set of supported opcodes is defined in exactly one place.
package mips_isa_pkg;

    // Field-tuple type codes presented on the loader's itype input
    localparam logic [1:0] TYPE_R   = 2'd0;
    localparam logic [1:0] TYPE_I   = 2'd1;
    localparam logic [1:0] TYPE_J   = 2'd2;
    localparam logic [1:0] TYPE_BAD = 2'd3;

    // R-type shares a single primary opcode; the operation lives in funct
    localparam logic [5:0] OP_RTYPE = 6'h00;

    // J-type opcodes
    localparam logic [5:0] OP_JX    = 6'h01;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;

    // I-type opcodes: branches, ALU immediates, loads/stores
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_BLT   = 6'h12;
    localparam logic [5:0] OP_BGE   = 6'h13;
    localparam logic [5:0] OP_BLTU  = 6'h14;
    localparam logic [5:0] OP_BGEU  = 6'h15;
    localparam logic [5:0] OP_BGT   = 6'h16;
    localparam logic [5:0] OP_BLE   = 6'h17;
    localparam logic [5:0] OP_MULI  = 6'h1C;
    localparam logic [5:0] OP_DIVI  = 6'h1D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Opcode sets as packed tables so membership tests can be generated
    // element by element; order carries no meaning.
    localparam int NUM_I_OPS = 19;
    localparam int NUM_J_OPS = 3;

    localparam logic [NUM_I_OPS-1:0][5:0] I_OPCODES = {
        OP_BEQ,  OP_BNE,  OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI,
        OP_XORI, OP_LUI,  OP_BLT,  OP_BGE,   OP_BLTU, OP_BGEU, OP_BGT,
        OP_BLE,  OP_MULI, OP_DIVI, OP_LW,    OP_SW
    };

    localparam logic [NUM_J_OPS-1:0][5:0] J_OPCODES = {
        OP_JX, OP_J, OP_JAL
    };

    // Loader session states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } load_state_t;

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: turns an R/I/J field tuple into a 32-bit mini-MIPS
// word and flags whether the opcode is in the supported set for that type.
module instr_pack
    import mips_isa_pkg::*;
(
    input  logic [1:0]  itype,
    input  logic [5:0]  opcode,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [5:0]  funct,
    input  logic [15:0] imm,
    input  logic [25:0] jaddr,
    output logic [31:0] word,
    output logic        legal
);

    logic [NUM_I_OPS-1:0] i_hit;
    logic [NUM_J_OPS-1:0] j_hit;

    genvar gi;

    // One comparator per supported I-type opcode
    generate
        for (gi = 0; gi < NUM_I_OPS; gi++) begin : g_i_hit
            assign i_hit[gi] = (opcode == I_OPCODES[gi]);
        end
    endgenerate

    // One comparator per supported J-type opcode
    generate
        for (gi = 0; gi < NUM_J_OPS; gi++) begin : g_j_hit
            assign j_hit[gi] = (opcode == J_OPCODES[gi]);
        end
    endgenerate

    // Select the field layout for the tuple type and decide legality.
    // The R-type word always carries opcode 0 regardless of the opcode
    // input; the loader never writes illegal words anyway.
    always_comb begin
        word  = 32'h0000_0000;
        legal = 1'b0;
        case (itype)
            TYPE_R: begin
                word  = {OP_RTYPE, rs, rt, rd, shamt, funct};
                legal = (opcode == OP_RTYPE);
            end
            TYPE_I: begin
                word  = {opcode, rs, rt, imm};
                legal = |i_hit;
            end
            TYPE_J: begin
                word  = {opcode, jaddr};
                legal = |j_hit;
            end
            default: begin
                word  = 32'h0000_0000;
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instruction_encode_loader.sv
// Program loader: accepts a counted session of R/I/J field tuples, encodes
// each into a mini-MIPS word and writes legal words to consecutive
// instruction-memory addresses through a registered one-cycle write port.
// Illegal tuples are consumed and counted but never written.
module instruction_encode_loader
    import mips_isa_pkg::*;
#(
    parameter int ADDR_W = 10
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        itype,
    input  logic [5:0]        opcode,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [5:0]        funct,
    input  logic [15:0]       imm,
    input  logic [25:0]       jaddr,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              illegal,
    output logic [7:0]        err_cnt,
    output logic [ADDR_W:0]   wr_cnt,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W:0] REM_ONE = (ADDR_W+1)'(1);

    load_state_t       state_reg;
    load_state_t       state_next;

    logic [ADDR_W-1:0] wptr_reg;
    logic [ADDR_W:0]   remaining_reg;
    logic              mem_we_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [31:0]       mem_wdata_reg;
    logic              illegal_reg;
    logic [7:0]        err_cnt_reg;
    logic [ADDR_W:0]   wr_cnt_reg;

    logic [31:0]       packed_word;
    logic              packed_legal;
    logic              take;
    logic              session_start;

    instr_pack u_pack (
        .itype  (itype),
        .opcode (opcode),
        .rs     (rs),
        .rt     (rt),
        .rd     (rd),
        .shamt  (shamt),
        .funct  (funct),
        .imm    (imm),
        .jaddr  (jaddr),
        .word   (packed_word),
        .legal  (packed_legal)
    );

    // abort wins over a same-cycle tuple, so the tuple is not consumed
    assign take          = (state_reg == ST_LOAD) && in_valid && !abort;
    assign session_start = (state_reg == ST_IDLE) && start;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: empty sessions skip straight to DONE, the last
    // accepted tuple ends LOAD, abort drops back to IDLE without done.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = (count == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (take && (remaining_reg == REM_ONE)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State-decoded outputs; done lines up with the final registered write
    always_comb begin
        in_ready = (state_reg == ST_LOAD);
        busy     = (state_reg != ST_IDLE);
        done     = (state_reg == ST_DONE);
    end

    // Session counters and the registered memory write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_reg      <= '0;
            remaining_reg <= '0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            illegal_reg   <= 1'b0;
            err_cnt_reg   <= '0;
            wr_cnt_reg    <= '0;
        end else begin
            mem_we_reg  <= 1'b0;
            illegal_reg <= 1'b0;

            if (session_start) begin
                wptr_reg      <= base_addr;
                remaining_reg <= count;
                err_cnt_reg   <= '0;
                wr_cnt_reg    <= '0;
            end

            if (take) begin
                remaining_reg <= remaining_reg - REM_ONE;
                if (packed_legal) begin
                    // Address and data only move on a real write so the
                    // port holds its last values while mem_we is low.
                    mem_we_reg    <= 1'b1;
                    mem_addr_reg  <= wptr_reg;
                    mem_wdata_reg <= packed_word;
                    wptr_reg      <= wptr_reg + ADDR_W'(1);
                    wr_cnt_reg    <= wr_cnt_reg + REM_ONE;
                end else begin
                    illegal_reg <= 1'b1;
                    if (err_cnt_reg != 8'hFF) begin
                        err_cnt_reg <= err_cnt_reg + 8'd1;
                    end
                end
            end
        end
    end

    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign illegal   = illegal_reg;
    assign err_cnt   = err_cnt_reg;
    assign wr_cnt    = wr_cnt_reg;

endmodule
